// File: rtl/sky130_ajc_ip__brownout_monitor_if.sv
// Pin bundle between the brown-out supervisor and its system-side controller.
// The master drives enable, detector flags and handshakes; the slave returns reset and status.
interface sky130_ajc_ip__brownout_monitor_if #(
  parameter int CNT_W = 8
);
  logic             ena;
  logic             brout_in;
  logic             vunder_in;
  logic             irq_ack;
  logic             clr_cnt;
  logic             sys_resetb;
  logic             irq;
  logic [1:0]       state;
  logic [1:0]       cause;
  logic [CNT_W-1:0] evt_cnt;

  modport master (
    output ena, brout_in, vunder_in, irq_ack, clr_cnt,
    input  sys_resetb, irq, state, cause, evt_cnt
  );

  modport slave (
    input  ena, brout_in, vunder_in, irq_ack, clr_cnt,
    output sys_resetb, irq, state, cause, evt_cnt
  );
endinterface

// File: rtl/sky130_ajc_ip__brownout_monitor.sv
// Brown-out supervisor: syncs/debounces detector flags and drives a stretched system reset.
// Optional event counter enabled with `define BROWNOUT_MON_EVCNT_EN.
module sky130_ajc_ip__brownout_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4,
  parameter int HOLD_CYCLES = 1024,
  parameter int CNT_W       = 8
) (
  input  logic                            clk,
  input  logic                            resetb,
  sky130_ajc_ip__brownout_monitor_if.slave bus
);

  localparam int DEB_W  = 4;
  localparam int HOLD_W = 16;
  localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEB_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_DISABLED = 2'b00,
    ST_NORMAL   = 2'b01,
    ST_BROWNOUT = 2'b10,
    ST_HOLDOFF  = 2'b11
  } state_e;

  function automatic logic [DEB_W-1:0] deb_sat_inc(input logic [DEB_W-1:0] v);
    return (v >= DEB_MAX) ? DEB_MAX : v + DEB_W'(1);
  endfunction

  logic [SYNC_STAGES-1:0] brout_sync_q, brout_sync_d;
  logic [SYNC_STAGES-1:0] vunder_sync_q, vunder_sync_d;
  logic                   brout_s, vunder_s;
  logic [DEB_W-1:0]       deb_cnt_q, deb_cnt_d;
  logic                   brout_q;
  state_e                 state_q, state_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic                   sys_resetb_q, sys_resetb_d;
  logic                   irq_q, irq_d;
  logic [1:0]             cause_q, cause_d;
  logic                   evt;

  // Input synchronizers and brown-out debounce
  always_comb begin
    brout_sync_d  = {brout_sync_q[SYNC_STAGES-2:0], bus.brout_in};
    vunder_sync_d = {vunder_sync_q[SYNC_STAGES-2:0], bus.vunder_in};
    brout_s       = brout_sync_q[SYNC_STAGES-1];
    vunder_s      = vunder_sync_q[SYNC_STAGES-1];
    deb_cnt_d     = brout_s ? deb_sat_inc(deb_cnt_q) : '0;
    // Qualify on the edge the counter reaches DEB_CYCLES so the event lands on that same edge.
    brout_q       = (deb_cnt_d == DEB_MAX);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      brout_sync_q  <= '0;
      vunder_sync_q <= '0;
      deb_cnt_q     <= '0;
    end else begin
      brout_sync_q  <= brout_sync_d;
      vunder_sync_q <= vunder_sync_d;
      deb_cnt_q     <= deb_cnt_d;
    end
  end

  // Supervisor FSM and hold-off timer
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    evt     = 1'b0;
    if (!bus.ena) begin
      state_d = ST_DISABLED;
    end else begin
      case (state_q)
        ST_DISABLED: state_d = ST_NORMAL;
        ST_NORMAL: begin
          if (brout_q || vunder_s) begin
            state_d = ST_BROWNOUT;
            evt     = 1'b1;
          end
        end
        ST_BROWNOUT: begin
          if (!brout_s && !vunder_s) begin
            state_d = ST_HOLDOFF;
            hold_d  = HOLD_LOAD;
          end
        end
        ST_HOLDOFF: begin
          // Re-entry uses raw synced flags: any flicker restarts the full stretch.
          if (brout_s || vunder_s) begin
            state_d = ST_BROWNOUT;
          end else if (hold_q == '0) begin
            state_d = ST_NORMAL;
          end else begin
            hold_d = hold_q - HOLD_W'(1);
          end
        end
        default: state_d = ST_DISABLED;
      endcase
    end
  end

  always_comb begin
    sys_resetb_d = !((state_d == ST_BROWNOUT) || (state_d == ST_HOLDOFF));
    irq_d        = irq_q;
    cause_d      = cause_q;
    if (evt) begin
      irq_d   = 1'b1;
      cause_d = {vunder_s, brout_q};
    end else if (bus.irq_ack) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q      <= ST_DISABLED;
      hold_q       <= '0;
      sys_resetb_q <= 1'b1;
      irq_q        <= 1'b0;
      cause_q      <= 2'b00;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      sys_resetb_q <= sys_resetb_d;
      irq_q        <= irq_d;
      cause_q      <= cause_d;
    end
  end

`ifdef BROWNOUT_MON_EVCNT_EN
  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] evt_cnt_q, evt_cnt_d;

  // A clear coinciding with an event leaves exactly that one event counted.
  always_comb begin
    evt_cnt_d = evt_cnt_q;
    if (bus.clr_cnt) begin
      evt_cnt_d = evt ? CNT_W'(1) : '0;
    end else if (evt) begin
      evt_cnt_d = cnt_sat_inc(evt_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      evt_cnt_q <= '0;
    end else begin
      evt_cnt_q <= evt_cnt_d;
    end
  end

  assign bus.evt_cnt = evt_cnt_q;
`else
  logic unused_clr_cnt;
  assign unused_clr_cnt = bus.clr_cnt;
  assign bus.evt_cnt    = '0;
`endif

  assign bus.sys_resetb = sys_resetb_q;
  assign bus.irq        = irq_q;
  assign bus.state      = state_q;
  assign bus.cause      = cause_q;

endmodule
